norm_collector: RTL and testbench
=================================

# norm_collector

Downstream stage of the normalizer: consumes its two serial normalized lanes (one element per valid cycle, COL elements per row) and reassembles each lane into a full row vector. Each element is saturated to W_OUT bits. Completed row pairs are buffered in a small first-word-fall-through FIFO and drained over a valid/ready interface to the output SRAM writer, which also receives a wrapping row address. Same clock domain as the normalizer's read side.

## Interface
- W_IN, 16, width of each incoming normalized element (unsigned)
- COL, 8, elements per row; power of 2, ≥2
- W_OUT, 8, stored element width; W_OUT ≤ W_IN
- DEPTH, 4, FIFO depth in row pairs; power of 2, ≥2
- ADDR_W, 8, output row address width

Ports:
- Clock and reset: clk is the clock; reset is synchronous and active-high.
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  one element per lane is present this cycle
- in_data_1  input  W_IN  lane-1 element
- in_data_2  input  W_IN  lane-2 element
- out_valid  output  1  FIFO head holds a complete row pair
- out_ready  input  1  consumer accepts the head this cycle
- out_row_1  output  COL*W_OUT  lane-1 row; element k at bits [k*W_OUT +: W_OUT]
- out_row_2  output  COL*W_OUT  lane-2 row, same packing
- out_addr  output  ADDR_W  row address of the head
- occupancy  output  $clog2(DEPTH)+1  rows currently in FIFO
- overflow  output  1  sticky: a completed row pair was dropped

## Operation
- Saturation: e = (in > 2^W_OUT−1) ? 2^W_OUT−1 : in[W_OUT−1:0]. The normalizer can produce exactly 256, which must store as 255 when W_OUT=8.
- Assembly counter idx (0..COL−1):
  - On an edge with in_valid, the saturated lane elements are written to asm_1[idx] and asm_2[idx], then idx increments.
  - After slot COL−1 is written, idx wraps to 0.
  - The first element of a row lands in slot 0.
- in_valid may be non-contiguous; idx holds across gaps. There is no in_ready: the input cannot be stalled.
- Completion: on an edge where in_valid && idx==COL−1, the full row pair is pushed. The pushed data is {asm slots 0..COL−2, current elements}.
  - The push is accepted if occupancy<DEPTH, or if a pop occurs on the same edge.
  - Otherwise the row pair is dropped, overflow is set to 1, and idx still wraps to 0.
- FIFO is first-word-fall-through:
  - out_valid = (occupancy != 0).
  - out_row_1, out_row_2 and out_addr reflect the head.
  - Pop occurs on any edge with out_valid && out_ready.
- out_addr:
  - Pop counter starting at 0, incremented per pop, wrapping from 2^ADDR_W−1 to 0.
  - Dropped rows consume no address.
- Simultaneous push and pop: occupancy is unchanged. With the FIFO empty, only a push can occur.
- out_ready while out_valid=0: no effect.
- overflow clears only on reset.

## Timing
- Reset (edge with reset=1) sets to 0: idx, occupancy, FIFO pointers, out_addr, overflow, and all asm slots. Consequences:
  - out_valid=0.
  - out_row_1/out_row_2 read 0 while empty; their value is don't-care while out_valid=0.
  - reset takes priority over in_valid and out_ready on the same edge.
- Reset mid-row discards the partial row; the next in_valid lands in slot 0.
- Latency: last element accepted at edge N with the FIFO empty gives out_valid=1 in the cycle after edge N. If popped at edge N+1, out_valid=0 after it.
- Throughput:
  - One row pair per COL input cycles.
  - One pop per cycle.
  - With out_ready held high the FIFO never exceeds 1 entry.
- Full + pop on the completing edge: the push is accepted, occupancy stays DEPTH, and overflow stays 0.
- Head data must remain stable while out_valid && !out_ready.

## Test plan
- Basic row: reset, then 8 contiguous in_valid with lane1=0..7 and lane2=100..107, out_ready=1. Required: exactly one cycle of out_valid. out_row_1 slot k = k; out_row_2 slot k = 100+k; out_addr=0; occupancy returns to 0.
- Saturation: lane1 sequence 256, 255, 0, 65535, 1, 2, 3, 4. Required: stored 255, 255, 0, 255, 1, 2, 3, 4.
- Gapped input + backpressure:
  - Elements with 1–3 idle cycles between them and out_ready=0; 3 rows sent. Required: occupancy=3 and the head is stable.
  - Then out_ready=1. Required: 3 pops with out_addr 0, 1, 2 in order.
- Overflow:
  - out_ready=0 and 5 rows sent with DEPTH=4. Required: the 5th row is dropped and overflow=1 from the completing edge. Draining yields rows 1–4 at addresses 0–3.
  - A 6th row then yields address 4.
- Full with simultaneous pop: FIFO full, out_ready=1 on the completing edge. Required: no drop, overflow=0, occupancy stays 4.
- Reset mid-row + address wrap:
  - Send 3 elements, reset, then a full row. Required: the row starts at slot 0 and out_addr=0.
  - Pop 256 rows. Required: out_addr wraps 255→0.

Source files
------------

// File: rtl/norm_collector.sv
// Reassembles the normalizer's two serial lanes into saturated row vectors.
// Completed row pairs are queued in a small FWFT FIFO for the SRAM writer.
module norm_collector #(
    parameter int W_IN   = 16,
    parameter int COL    = 8,
    parameter int W_OUT  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [W_IN-1:0]           in_data_1,
    input  logic [W_IN-1:0]           in_data_2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COL*W_OUT-1:0]      out_row_1,
    output logic [COL*W_OUT-1:0]      out_row_2,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      overflow
);

    localparam int IDX_W = $clog2(COL);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ROW_W = COL * W_OUT;

    localparam logic [W_IN-1:0]  SAT_MAX  = {W_IN{1'b1}} >> (W_IN - W_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    function automatic logic [W_OUT-1:0] saturate(input logic [W_IN-1:0] x);
        return (x > SAT_MAX) ? {W_OUT{1'b1}} : x[W_OUT-1:0];
    endfunction

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [W_OUT-1:0]  asm_1_q [COL];
    logic [W_OUT-1:0]  asm_1_d [COL];
    logic [W_OUT-1:0]  asm_2_q [COL];
    logic [W_OUT-1:0]  asm_2_d [COL];
    logic [ROW_W-1:0]  mem_1_q [DEPTH];
    logic [ROW_W-1:0]  mem_1_d [DEPTH];
    logic [ROW_W-1:0]  mem_2_q [DEPTH];
    logic [ROW_W-1:0]  mem_2_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;

    logic [W_OUT-1:0]  sat_1, sat_2;
    logic [ROW_W-1:0]  push_row_1, push_row_2;
    logic              pop, complete, push;

    // The completing element goes straight into the pushed row; its asm slot is never read.
    always_comb begin
        sat_1 = saturate(in_data_1);
        sat_2 = saturate(in_data_2);
        push_row_1 = '0;
        push_row_2 = '0;
        for (int k = 0; k < COL; k++) begin
            push_row_1[k*W_OUT +: W_OUT] = (k == COL - 1) ? sat_1 : asm_1_q[k];
            push_row_2[k*W_OUT +: W_OUT] = (k == COL - 1) ? sat_2 : asm_2_q[k];
        end
    end

    // A pop on the completing edge frees the slot, so a full FIFO can still accept.
    assign pop      = (occ_q != '0) && out_ready;
    assign complete = in_valid && (idx_q == LAST_IDX);
    assign push     = complete && ((occ_q != FULL_OCC) || pop);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx_d    = idx_q;
        asm_1_d  = asm_1_q;
        asm_2_d  = asm_2_q;
        mem_1_d  = mem_1_q;
        mem_2_d  = mem_2_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        ovf_d    = ovf_q;

        if (in_valid) begin
            asm_1_d[idx_q] = sat_1;
            asm_2_d[idx_q] = sat_2;
            idx_d          = idx_q + IDX_W'(1);
        end

        if (push) begin
            mem_1_d[wr_ptr_q] = push_row_1;
            mem_2_d[wr_ptr_q] = push_row_2;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(1);
        end

        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

        if (complete && !push) begin
            ovf_d = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q    <= '0;
            asm_1_q  <= '{default: '0};
            asm_2_q  <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            asm_1_q  <= asm_1_d;
            asm_2_q  <= asm_2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: FIFO storage is not reset; the head is masked to 0 while empty, so stale contents never leak out.
    always_ff @(posedge clk) begin
        mem_1_q <= mem_1_d;
        mem_2_q <= mem_2_d;
    end

    assign out_valid = (occ_q != '0);
    assign out_row_1 = out_valid ? mem_1_q[rd_ptr_q] : '0;
    assign out_row_2 = out_valid ? mem_2_q[rd_ptr_q] : '0;
    assign out_addr  = addr_q;
    assign occupancy = occ_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_norm_collector.sv
// Directed and randomized bench for norm_collector against a queue-based row model.
module tb_norm_collector;

    localparam int W_IN   = 16;
    localparam int COL    = 8;
    localparam int W_OUT  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int ROW_W  = COL * W_OUT;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [W_IN-1:0]   in_data_1 = '0;
    logic [W_IN-1:0]   in_data_2 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ROW_W-1:0]  out_row_1;
    logic [ROW_W-1:0]  out_row_2;
    logic [ADDR_W-1:0] out_addr;
    logic [OCC_W-1:0]  occupancy;
    logic              overflow;

    norm_collector #(
        .W_IN(W_IN), .COL(COL), .W_OUT(W_OUT), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_data_1(in_data_1), .in_data_2(in_data_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row_1(out_row_1), .out_row_2(out_row_2),
        .out_addr(out_addr), .occupancy(occupancy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: queue of completed row pairs plus the partially collected row.
    logic [ROW_W-1:0] q1[$];
    logic [ROW_W-1:0] q2[$];
    logic [W_OUT-1:0] cur1 [COL];
    logic [W_OUT-1:0] cur2 [COL];
    int               cur_n = 0;
    int               m_pops = 0;
    bit               m_ovf = 1'b0;

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W_OUT-1:0] sat(input logic [W_IN-1:0] x);
        int unsigned v   = x;
        int unsigned lim = (1 << W_OUT) - 1;
        return (v > lim) ? W_OUT'(lim) : W_OUT'(v);
    endfunction

    function automatic logic [W_IN-1:0] rand_elem();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'(256);
            2:       return 16'($urandom_range(0, 255));
            default: return 16'($urandom_range(250, 260));
        endcase
    endfunction

    task automatic compare();
        check("out_valid", ROW_W'(out_valid), ROW_W'(q1.size() != 0));
        check("occupancy", ROW_W'(occupancy), ROW_W'(q1.size()));
        check("overflow", ROW_W'(overflow), ROW_W'(m_ovf));
        if (q1.size() != 0) begin
            check("head_row_1", out_row_1, q1[0]);
            check("head_row_2", out_row_2, q2[0]);
            check("head_addr", ROW_W'(out_addr), ROW_W'(m_pops % (1 << ADDR_W)));
        end
    endtask

    // One clock: drive at the falling edge, compare, advance the model, cross the rising edge.
    task automatic step(input bit v, input logic [W_IN-1:0] d1, input logic [W_IN-1:0] d2, input bit rdy);
        logic [ROW_W-1:0] r1, r2;
        in_valid  = v;
        in_data_1 = d1;
        in_data_2 = d2;
        out_ready = rdy;
        #1;
        compare();
        if (rdy && q1.size() != 0) begin
            void'(q1.pop_front());
            void'(q2.pop_front());
            m_pops++;
        end
        if (v) begin
            cur1[cur_n] = sat(d1);
            cur2[cur_n] = sat(d2);
            cur_n++;
            if (cur_n == COL) begin
                cur_n = 0;
                for (int k = 0; k < COL; k++) begin
                    r1[k*W_OUT +: W_OUT] = cur1[k];
                    r2[k*W_OUT +: W_OUT] = cur2[k];
                end
                if (q1.size() < DEPTH) begin
                    q1.push_back(r1);
                    q2.push_back(r2);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data_1 = rand_elem();
        in_data_2 = rand_elem();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q1.delete();
        q2.delete();
        cur_n  = 0;
        m_pops = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, 16'($urandom), 16'($urandom), rdy);
    endtask

    task automatic send_row(input int gap_min, input int gap_max, input bit rdy, input bit last_rdy);
        int g;
        for (int k = 0; k < COL; k++) begin
            step(1'b1, rand_elem(), rand_elem(), (k == COL - 1) ? last_rdy : rdy);
            if (k != COL - 1) begin
                g = $urandom_range(gap_max, gap_min);
                idle(g, rdy);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("reset_valid", ROW_W'(out_valid), '0);
        check("reset_occ", ROW_W'(occupancy), '0);
        check("reset_ovf", ROW_W'(overflow), '0);
        check("reset_row_1", out_row_1, '0);

        // Basic row with known data
        for (int k = 0; k < COL; k++) step(1'b1, 16'(k), 16'(100 + k), 1'b1);
        check("basic_valid", ROW_W'(out_valid), ROW_W'(1));
        check("basic_row_1", out_row_1, 64'h0706050403020100);
        check("basic_row_2", out_row_2, 64'h6B6A696867666564);
        check("basic_addr", ROW_W'(out_addr), '0);
        idle(1, 1'b1);
        check("basic_valid_after_pop", ROW_W'(out_valid), '0);
        check("basic_occ_after_pop", ROW_W'(occupancy), '0);
        idle(2, 1'b1);

        // Saturation
        begin
            logic [W_IN-1:0] s1 [COL];
            s1 = '{16'd256, 16'd255, 16'd0, 16'd65535, 16'd1, 16'd2, 16'd3, 16'd4};
            for (int k = 0; k < COL; k++) step(1'b1, s1[k], rand_elem(), 1'b1);
        end
        check("sat_row_1", out_row_1, 64'h04030201FF00FFFF);
        idle(3, 1'b1);

        // Gapped input under backpressure, then drain
        do_reset();
        repeat (3) send_row(1, 3, 1'b0, 1'b0);
        check("gap_occ", ROW_W'(occupancy), ROW_W'(3));
        idle(2, 1'b0);
        idle(4, 1'b1);
        check("gap_drained", ROW_W'(occupancy), '0);

        // Overflow: fifth row dropped, drain, sixth row gets the next address
        do_reset();
        repeat (5) send_row(0, 2, 1'b0, 1'b0);
        check("ovf_set", ROW_W'(overflow), ROW_W'(1));
        check("ovf_occ", ROW_W'(occupancy), ROW_W'(DEPTH));
        idle(5, 1'b1);
        send_row(0, 0, 1'b1, 1'b1);
        check("ovf_next_addr", ROW_W'(out_addr), ROW_W'(4));
        check("ovf_sticky", ROW_W'(overflow), ROW_W'(1));
        idle(2, 1'b1);

        // Full FIFO with a pop on the completing edge
        do_reset();
        repeat (DEPTH) send_row(0, 1, 1'b0, 1'b0);
        send_row(0, 1, 1'b0, 1'b1);
        check("fullpop_ovf", ROW_W'(overflow), '0);
        check("fullpop_occ", ROW_W'(occupancy), ROW_W'(DEPTH));
        idle(DEPTH + 1, 1'b1);

        // Reset mid-row, then address wrap
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, rand_elem(), rand_elem(), 1'b1);
        do_reset();
        for (int k = 0; k < COL; k++) step(1'b1, 16'(10 + k), rand_elem(), 1'b1);
        check("midreset_row_1", out_row_1, 64'h11100F0E0D0C0B0A);
        check("midreset_addr", ROW_W'(out_addr), '0);
        repeat (255) send_row(0, 0, 1'b1, 1'b1);
        check("wrap_addr_255", ROW_W'(out_addr), ROW_W'(255));
        send_row(0, 0, 1'b1, 1'b1);
        check("wrap_valid", ROW_W'(out_valid), ROW_W'(1));
        check("wrap_addr_0", ROW_W'(out_addr), '0);
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
